// File: rtl/biometrics_sequencer.sv
// Enroll/verify mode controller for the voice-biometrics pipeline (FFT -> features -> BLE/classifier).
// Optional frame watchdog: define BIOMETRICS_SEQ_TIMEOUT_EN. VERIFY_FRAMES must not exceed ENROLL_FRAMES.
//
// state  | meaning
// IDLE   | waiting for an enroll or verify request
// ARM_E  | enroll requested, discarding the partial frame in flight
// ENROLL | streaming frames to BLE, write_enable high
// ARM_V  | verify requested, discarding the partial frame in flight
// VERIFY | classifying frames, predict_enable high
// DRAIN  | all frames sent, collecting outstanding verdicts
// REPORT | one-cycle session result
module biometrics_sequencer #(
  parameter int ENROLL_FRAMES  = 64,
  parameter int VERIFY_FRAMES  = 16,
  parameter int VOTE_THRESHOLD = 10,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               enroll_req_in,
  input  logic                               verify_req_in,
  input  logic                               abort_in,
  input  logic                               fft_valid_in,
  input  logic                               fft_ready_in,
  input  logic                               fft_last_in,
  input  logic                               verdict_valid_in,
  input  logic                               verdict_in,
  output logic                               write_enable_out,
  output logic                               predict_enable_out,
  output logic                               busy_out,
  output logic                               result_valid_out,
  output logic                               result_match_out,
  output logic                               timeout_out,
  output logic [$clog2(ENROLL_FRAMES+1)-1:0] frame_count_out
);

  localparam int FCW = $clog2(ENROLL_FRAMES + 1);
  localparam int VCW = $clog2(VERIFY_FRAMES + 1);

  localparam logic [FCW-1:0] ENROLL_LAST  = FCW'(ENROLL_FRAMES);
  localparam logic [FCW-1:0] VERIFY_LAST  = FCW'(VERIFY_FRAMES);
  localparam logic [VCW-1:0] VERDICT_FULL = VCW'(VERIFY_FRAMES);
  localparam logic [VCW-1:0] VOTE_MIN     = VCW'(VOTE_THRESHOLD);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM_E  = 3'd1;
  localparam logic [2:0] ENROLL = 3'd2;
  localparam logic [2:0] ARM_V  = 3'd3;
  localparam logic [2:0] VERIFY = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
  localparam logic [2:0] REPORT = 3'd6;

  logic [2:0]     state, state_nxt;
  logic [FCW-1:0] frame_cnt, frame_cnt_nxt;
  logic [VCW-1:0] verdict_cnt, verdict_cnt_nxt;
  logic [VCW-1:0] votes, votes_nxt;
  logic           fb;
  logic           verdict_win;
  logic           timeout_hit;
  logic           match_nxt;
  logic           timeout_nxt;
  logic           session_start;

  assign fb          = fft_valid_in & fft_ready_in & fft_last_in;
  assign verdict_win = (state == VERIFY) || (state == DRAIN);

`ifdef BIOMETRICS_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wdog;
  logic           wd_run;
  logic           wd_clear;

  assign wd_run      = state inside {ARM_E, ENROLL, ARM_V, VERIFY, DRAIN};
  assign wd_clear    = fb || ((state == DRAIN) && verdict_valid_in);
  assign timeout_hit = wd_run && !wd_clear && (wdog == '0);

  // Down-counter reloaded on every stream event; terminal count is zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wdog <= '0;
    end else if (!wd_run || wd_clear) begin
      wdog <= WD_LOAD;
    end else if (wdog != '0) begin
      wdog <= wdog - 1'b1;
    end
  end
`else
  // Watchdog compiled out; the limit only matters in the timeout build.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    frame_cnt_nxt   = frame_cnt;
    verdict_cnt_nxt = verdict_cnt;
    votes_nxt       = votes;
    if (fb && ((state == ENROLL) || (state == VERIFY))) begin
      frame_cnt_nxt = frame_cnt + 1'b1;
    end
    if (verdict_win && verdict_valid_in) begin
      if (verdict_cnt != VERDICT_FULL) begin
        verdict_cnt_nxt = verdict_cnt + 1'b1;
      end
      if (verdict_in && (votes != VERDICT_FULL)) begin
        votes_nxt = votes + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    match_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    if ((state != IDLE) && abort_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enroll_req_in) begin
            state_nxt = ARM_E;
          end else if (verify_req_in) begin
            state_nxt = ARM_V;
          end
        end
        ARM_E:  if (fb) state_nxt = ENROLL;
        ARM_V:  if (fb) state_nxt = VERIFY;
        ENROLL: if (fb && (frame_cnt_nxt == ENROLL_LAST)) state_nxt = REPORT;
        VERIFY: if (fb && (frame_cnt_nxt == VERIFY_LAST)) state_nxt = DRAIN;
        DRAIN: begin
          if (verdict_cnt_nxt == VERDICT_FULL) begin
            state_nxt = REPORT;
            match_nxt = (votes_nxt >= VOTE_MIN);
          end
        end
        REPORT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (timeout_hit) begin
        state_nxt   = REPORT;
        match_nxt   = 1'b0;
        timeout_nxt = 1'b1;
      end
    end
  end

  assign session_start = (state == IDLE) && (state_nxt != IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      frame_cnt          <= '0;
      verdict_cnt        <= '0;
      votes              <= '0;
      write_enable_out   <= 1'b0;
      predict_enable_out <= 1'b0;
      busy_out           <= 1'b0;
      result_valid_out   <= 1'b0;
      result_match_out   <= 1'b0;
      timeout_out        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (session_start) begin
        frame_cnt   <= '0;
        verdict_cnt <= '0;
        votes       <= '0;
      end else begin
        frame_cnt   <= frame_cnt_nxt;
        verdict_cnt <= verdict_cnt_nxt;
        votes       <= votes_nxt;
      end
      write_enable_out   <= (state_nxt == ENROLL);
      predict_enable_out <= (state_nxt == VERIFY);
      busy_out           <= (state_nxt != IDLE);
      result_valid_out   <= (state_nxt == REPORT);
      result_match_out   <= match_nxt;
      timeout_out        <= timeout_nxt;
    end
  end

  assign frame_count_out = frame_cnt;

endmodule

// File: tb/tb_biometrics_sequencer.sv
// Self-checking bench for biometrics_sequencer: vector table of verify sessions plus hand-written corner cases.
// Session results are predicted into a scoreboard queue and checked when result_valid_out pulses.
module tb_biometrics_sequencer;

  localparam int EF = 4;
  localparam int VF = 4;
  localparam int VT = 3;
  localparam int TC = 1000;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       enroll_req_in = 1'b0;
  logic       verify_req_in = 1'b0;
  logic       abort_in = 1'b0;
  logic       fft_valid_in = 1'b0;
  logic       fft_ready_in = 1'b0;
  logic       fft_last_in = 1'b0;
  logic       verdict_valid_in = 1'b0;
  logic       verdict_in = 1'b0;
  logic       write_enable_out;
  logic       predict_enable_out;
  logic       busy_out;
  logic       result_valid_out;
  logic       result_match_out;
  logic       timeout_out;
  logic [2:0] frame_count_out;

  biometrics_sequencer #(
    .ENROLL_FRAMES (EF),
    .VERIFY_FRAMES (VF),
    .VOTE_THRESHOLD(VT),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .enroll_req_in     (enroll_req_in),
    .verify_req_in     (verify_req_in),
    .abort_in          (abort_in),
    .fft_valid_in      (fft_valid_in),
    .fft_ready_in      (fft_ready_in),
    .fft_last_in       (fft_last_in),
    .verdict_valid_in  (verdict_valid_in),
    .verdict_in        (verdict_in),
    .write_enable_out  (write_enable_out),
    .predict_enable_out(predict_enable_out),
    .busy_out          (busy_out),
    .result_valid_out  (result_valid_out),
    .result_match_out  (result_match_out),
    .timeout_out       (timeout_out),
    .frame_count_out   (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       match;
    logic       tmo;
    logic [2:0] fc;
  } exp_t;

  typedef struct {
    logic [3:0] verdicts;
    logic       late;
    logic       match;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic er, input logic vr, input logic fb, input logic vv,
                       input logic vd, input logic ab);
    enroll_req_in    = er;
    verify_req_in    = vr;
    fft_valid_in     = fb;
    fft_ready_in     = fb;
    fft_last_in      = fb;
    verdict_valid_in = vv;
    verdict_in       = vd;
    abort_in         = ab;
    cyc();
    enroll_req_in    = 1'b0;
    verify_req_in    = 1'b0;
    fft_valid_in     = 1'b0;
    fft_ready_in     = 1'b0;
    fft_last_in      = 1'b0;
    verdict_valid_in = 1'b0;
    verdict_in       = 1'b0;
    abort_in         = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy_out && (n < max)) begin
      cyc();
      n++;
    end
    chk(name, busy_out, 0);
  endtask

  // Result monitor: every pulse must match the oldest prediction.
  exp_t e;
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (result_valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", result_valid_out, 0);
        end else begin
          e = sb.pop_front();
          chk("result_match", result_match_out, e.match);
          chk("result_timeout", timeout_out, e.tmo);
          chk("result_frames", frame_count_out, e.fc);
        end
      end else begin
        chk("flags_without_valid", {result_match_out, timeout_out}, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   n;
    vt[0] = '{4'b1011, 1'b1, 1'b1};
    vt[1] = '{4'b1001, 1'b1, 1'b0};
    vt[2] = '{4'b1111, 1'b0, 1'b1};
    vt[3] = '{4'b0000, 1'b1, 1'b0};
    vt[4] = '{4'b0111, 1'b0, 1'b1};
    vt[5] = '{4'b0101, 1'b0, 1'b0};

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_we", write_enable_out, 0);
    chk("rst_pe", predict_enable_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_rv", result_valid_out, 0);
    chk("rst_match", result_match_out, 0);
    chk("rst_tmo", timeout_out, 0);
    chk("rst_fc", frame_count_out, 0);
    rst_n_in = 1'b1;
    cyc();

    // Enroll requested mid-frame
    fft_valid_in = 1'b1; fft_ready_in = 1'b1; enroll_req_in = 1'b1;
    cyc();
    fft_valid_in = 1'b0; fft_ready_in = 1'b0; enroll_req_in = 1'b0;
    chk("e_busy", busy_out, 1);
    chk("e_arm_we", write_enable_out, 0);
    fft_valid_in = 1'b1; fft_last_in = 1'b1;
    cyc();
    fft_valid_in = 1'b0; fft_last_in = 1'b0;
    chk("e_noready_we", write_enable_out, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("e_we_rise", write_enable_out, 1);
    chk("e_fc0", frame_count_out, 0);
    for (int f = 1; f <= 3; f++) begin
      drive(0, 0, 1, 0, 0, 0);
      chk("e_fc", frame_count_out, f);
      chk("e_we_hold", write_enable_out, 1);
    end
    sb.push_back(exp_t'{1'b0, 1'b0, 3'd4});
    drive(0, 0, 1, 0, 0, 0);
    chk("e_we_fall", write_enable_out, 0);
    chk("e_result_pulse", result_valid_out, 1);
    wait_idle("e_idle", 4);

    // Simultaneous requests choose enroll; verify request mid-enroll is ignored
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("s_we", write_enable_out, 1);
    chk("s_pe", predict_enable_out, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("s_vreq_pe", predict_enable_out, 0);
    chk("s_vreq_we", write_enable_out, 1);
    for (int f = 0; f < 4; f++) begin
      if (f == 3) sb.push_back(exp_t'{1'b0, 1'b0, 3'd4});
      drive(0, 0, 1, 0, 0, 0);
    end
    wait_idle("s_idle", 4);

    // Verify sessions from the table
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk("v_arm_pe", predict_enable_out, 0);
      drive(0, 0, 1, 0, 0, 0);
      chk("v_pe_rise", predict_enable_out, 1);
      for (int f = 0; f < 4; f++) begin
        if (f < 3) drive(0, 0, 0, 1, vt[i].verdicts[f], 0);
        if (f == 3) sb.push_back(exp_t'{vt[i].match, 1'b0, 3'd4});
        drive(0, 0, 1, (f == 3) && !vt[i].late, vt[i].verdicts[3], 0);
      end
      chk("v_pe_fall", predict_enable_out, 0);
      if (vt[i].late) begin
        drive(0, 0, 0, 1, vt[i].verdicts[3], 0);
        chk("v_result_latency", result_valid_out, 1);
      end
      wait_idle("v_idle", 6);
      drive(0, 0, 0, 1, 1, 0);
      chk("v_idle_verdict", busy_out, 0);
    end

    // Abort during VERIFY after two counted frames
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("a_fc", frame_count_out, 2);
    drive(0, 0, 0, 0, 0, 1);
    chk("a_pe", predict_enable_out, 0);
    chk("a_busy", busy_out, 0);
    repeat (3) cyc();

    // Abort beats the final verdict in DRAIN
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int f = 0; f < 4; f++) begin
      if (f < 3) drive(0, 0, 0, 1, 1, 0);
      drive(0, 0, 1, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 1, 1);
    chk("ad_rv", result_valid_out, 0);
    chk("ad_busy", busy_out, 0);
    repeat (3) cyc();

    // Reset asserted mid-enroll
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("r_fc", frame_count_out, 2);
    rst_n_in = 1'b0;
    #1;
    chk("r_we", write_enable_out, 0);
    chk("r_fc_clear", frame_count_out, 0);
    cyc();
    rst_n_in = 1'b1;
    repeat (3) cyc();
    chk("r_busy", busy_out, 0);
    chk("r_rv", result_valid_out, 0);

`ifdef BIOMETRICS_SEQ_TIMEOUT_EN
    drive(0, 1, 0, 0, 0, 0);
    sb.push_back(exp_t'{1'b0, 1'b1, 3'd0});
    drive(0, 0, 1, 0, 0, 0);
    n = 0;
    while (!result_valid_out && (n < 1100)) begin
      cyc();
      n++;
    end
    chk("t_tmo_seen", result_valid_out, 1);
    chk("t_tmo_delay", (n >= 995) && (n <= 1005), 1);
    wait_idle("t_idle", 4);
`else
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    n = 0;
    repeat (5000) begin
      cyc();
      if (timeout_out || result_valid_out) n++;
    end
    chk("t_no_pulse", n, 0);
    chk("t_still_busy", busy_out, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("t_abort_busy", busy_out, 0);
`endif

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
